// File: rtl/lsu_mem_responder_pkg.sv
// lsu_mem_responder_pkg: size masks, load-extension codes, LSU state encoding and alignment check
package lsu_mem_responder_pkg;
   localparam logic [3:0] HALF_WORD = 4'h3;
   localparam logic [3:0] WORD = 4'hF;
   localparam logic [1:0] SEXT_B = 2'b01;
   localparam logic [1:0] SEXT_H = 2'b10;
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
   function automatic logic misaligned(input logic [3:0] pmem, input logic [1:0] off);
      return (pmem == HALF_WORD && off[0]) || (pmem == WORD && off != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_mem_responder_if.sv
// lsu_mem_responder_if: valid/ready data bus between the LSU (master) and data memory (slave)
interface lsu_mem_responder_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
   logic req_valid, req_ready, req_we, rsp_valid;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0] req_wdata, rsp_rdata;
   logic [XLEN/8-1:0] req_wmask;
   modport master(output req_valid, req_we, req_addr, req_wdata, req_wmask,
                  input req_ready, rsp_valid, rsp_rdata);
   modport slave(input req_valid, req_we, req_addr, req_wdata, req_wmask,
                 output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/lsu_mem_responder_lane_align.sv
// lsu_mem_responder_lane_align: store data/mask lane shift and load extract with sign/zero extension
module lsu_mem_responder_lane_align
   import lsu_mem_responder_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int NL = XLEN / 8,
   localparam int OW = $clog2(NL)
) (
   input  logic [OW-1:0]   st_off,
   input  logic [NL-1:0]   st_mask,
   input  logic [XLEN-1:0] st_data,
   output logic [XLEN-1:0] st_wdata,
   output logic [NL-1:0]   st_wmask,
   input  logic [OW-1:0]   ld_off,
   input  logic [NL-1:0]   ld_mask,
   input  logic [1:0]      ld_sext,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);
   logic [XLEN-1:0] byte_mask, shifted;
   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < NL; i++) byte_mask[8*i +: 8] = {8{ld_mask[i]}};
   end
   assign st_wdata = st_data << {st_off, 3'b000};
   assign st_wmask = st_mask << st_off;
   assign shifted = (ld_rdata >> {ld_off, 3'b000}) & byte_mask;
   assign ld_data = ld_sext == SEXT_B ? {{(XLEN-8){shifted[7]}}, shifted[7:0]} :
                    ld_sext == SEXT_H ? {{(XLEN-16){shifted[15]}}, shifted[15:0]} : shifted;
endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: runs one valid/ready data-bus transaction per load/store, stalling the core
// until it completes; flags misaligned, load&store and timed-out accesses.
module lsu_mem_responder
   import lsu_mem_responder_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ADDR_W = 32,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               store,
   input  logic [7:0]         op_PMEM,
   input  logic [1:0]         op_load_sext,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [XLEN-1:0]    wdata,
   output logic               lsu_busy,
   output logic [XLEN-1:0]    lsu_rdata,
   output logic               lsu_err,
   lsu_mem_responder_if.master bus
);
   localparam int NL = XLEN / 8;
   localparam int OW = $clog2(NL);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   lsu_state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [OW-1:0] off_q;
   logic [NL-1:0] mask_q, wmask_nx;
   logic [1:0] sext_q;
   logic [XLEN-1:0] wdata_nx, ldata;
   logic legal, launch, tmo, timed_out, unused_pmem;
   assign unused_pmem = ^op_PMEM[7:NL];
   assign legal = !(load && store) && !misaligned(op_PMEM[3:0], addr[1:0]);
   assign launch = state == IDLE && (load || store) && legal;
   assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
   assign timed_out = tmo && ((state == REQ && !bus.req_ready) || (state == RESP && !bus.rsp_valid));

   lsu_mem_responder_lane_align #(.XLEN(XLEN)) u_align (
      .st_off(addr[OW-1:0]), .st_mask(op_PMEM[NL-1:0]), .st_data(wdata),
      .st_wdata(wdata_nx), .st_wmask(wmask_nx),
      .ld_off(off_q), .ld_mask(mask_q), .ld_sext(sext_q),
      .ld_rdata(bus.rsp_rdata), .ld_data(ldata)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = launch ? REQ : IDLE;
         REQ:     state_nx = bus.req_ready ? RESP : tmo ? DONE : REQ;
         RESP:    state_nx = (bus.rsp_valid || tmo) ? DONE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_valid = state == REQ;
      lsu_busy = launch || state == REQ || state == RESP;
   end

   // Counter restarts on every state change so REQ and RESP each get a full timeout window.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         lsu_err <= 1'b0;
         lsu_rdata <= '0;
         bus.req_we <= 1'b0;
         bus.req_addr <= '0;
         bus.req_wdata <= '0;
         bus.req_wmask <= '0;
         off_q <= '0;
         mask_q <= '0;
         sext_q <= '0;
      end else begin
         cnt <= (state_nx == state && (state == REQ || state == RESP)) ? cnt + 1'b1 : '0;
         lsu_err <= (state == IDLE && (load || store) && !legal) || timed_out;
         if (launch) begin
            bus.req_we <= store;
            bus.req_addr <= {addr[ADDR_W-1:OW], {OW{1'b0}}};
            bus.req_wdata <= wdata_nx;
            bus.req_wmask <= wmask_nx;
            off_q <= addr[OW-1:0];
            mask_q <= op_PMEM[NL-1:0];
            sext_q <= op_load_sext;
         end
         if (state == RESP && bus.rsp_valid && !bus.req_we) lsu_rdata <= ldata;
      end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb_lsu_mem_responder: scoreboard bench for lsu_mem_responder with an inline bus slave
module tb_lsu_mem_responder;
   localparam int TMO = 8;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   logic clk = 0, rst_n = 0, load = 0, store = 0;
   logic [7:0] op_PMEM = 0;
   logic [1:0] op_load_sext = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic lsu_busy, lsu_err;
   logic [31:0] lsu_rdata;
   int vectors = 0, miscompares = 0;
   logic [31:0] last_rdata = 0;
   req_t req_q[$];
   logic [31:0] rd_q[$];

   lsu_mem_responder_if #(.XLEN(32), .ADDR_W(32)) bus();

   lsu_mem_responder #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .store(store), .op_PMEM(op_PMEM),
      .op_load_sext(op_load_sext), .addr(addr), .wdata(wdata), .lsu_busy(lsu_busy),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_load(input logic [7:0] pmem, input logic [1:0] sext,
                                              input logic [1:0] off, input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * off);
      if (pmem == 8'h01) return sext == 2'b01 ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      if (pmem == 8'h03) return sext == 2'b10 ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      return s;
   endfunction

   // rdy_dly cycles of req_ready=0 before accepting; a huge value forces a timeout.
   task automatic run_access(input logic st, input logic [7:0] pmem, input logic [1:0] sext,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                             input int rdy_dly, input string name);
      req_t ex, er;
      logic [31:0] exp_rd;
      int nbusy = 0, nvalid = 0, waited = 0, exp_busy, exp_valid;
      bit hs = 0, got = 0, done = 0, tmo_case;
      tmo_case = rdy_dly >= TMO;
      exp_busy = tmo_case ? TMO + 1 : rdy_dly + 3;
      exp_valid = tmo_case ? TMO : rdy_dly + 1;
      ex.we = st;
      ex.addr = {a[31:2], 2'b00};
      ex.wdata = wd << (8 * a[1:0]);
      ex.wmask = pmem[3:0] << a[1:0];
      req_q.push_back(ex);
      if (!st && !tmo_case) last_rdata = model_load(pmem, sext, a[1:0], rsp);
      rd_q.push_back(last_rdata);
      @(posedge clk); #1;
      load = !st; store = st; op_PMEM = pmem; op_load_sext = sext; addr = a; wdata = wd;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         bus.rsp_valid = hs;
         bus.rsp_rdata = hs ? rsp : 32'h0BAD_0BAD;
         hs = 0;
         if (!lsu_busy) begin
            done = 1;
         end else begin
            nbusy++;
            if (bus.req_valid) begin
               if (!got) begin er = req_q.pop_front(); got = 1; end
               nvalid++;
               vectors++;
               if (bus.req_we !== er.we || bus.req_addr !== er.addr) begin
                  miscompares++;
                  $display("FAIL %s req we/addr got %b/%h want %b/%h", name, bus.req_we, bus.req_addr, er.we, er.addr);
               end
               if (st) begin
                  vectors++;
                  if (bus.req_wdata !== er.wdata || bus.req_wmask !== er.wmask) begin
                     miscompares++;
                     $display("FAIL %s req wdata/wmask got %h/%b want %h/%b", name, bus.req_wdata, bus.req_wmask, er.wdata, er.wmask);
                  end
               end
               bus.req_ready = waited >= rdy_dly;
               waited++;
               hs = bus.req_ready;
            end else begin
               bus.req_ready = 0;
            end
         end
      end
      load = 0; store = 0; bus.req_ready = 0; bus.rsp_valid = 0;
      exp_rd = rd_q.pop_front();
      if (!got) begin
         void'(req_q.pop_front());
         vectors++; miscompares++;
         $display("FAIL %s no bus request seen", name);
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s access never completed within 64 cycles", name);
      end
      vectors++;
      if (nbusy != exp_busy) begin
         miscompares++;
         $display("FAIL %s busy cycles got %0d want %0d", name, nbusy, exp_busy);
      end
      vectors++;
      if (nvalid != exp_valid) begin
         miscompares++;
         $display("FAIL %s req_valid cycles got %0d want %0d", name, nvalid, exp_valid);
      end
      vectors++;
      if (lsu_err !== tmo_case || bus.req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done err/req_valid got %b/%b want %b/0", name, lsu_err, bus.req_valid, tmo_case);
      end
      vectors++;
      if (lsu_rdata !== exp_rd) begin
         miscompares++;
         $display("FAIL %s lsu_rdata got %h want %h", name, lsu_rdata, exp_rd);
      end
      if (tmo_case) begin
         @(negedge clk);
         vectors++;
         if (lsu_err !== 1'b0 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after-timeout err/busy got %b/%b want 0/0", name, lsu_err, lsu_busy);
         end
      end
   endtask

   task automatic try_illegal(input logic ld, input logic st, input logic [7:0] pmem,
                              input logic [31:0] a, input string name);
      @(posedge clk); #1;
      load = ld; store = st; op_PMEM = pmem; addr = a; wdata = 32'h5555_AAAA;
      @(negedge clk);
      vectors++;
      if (lsu_busy !== 1'b0 || bus.req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s busy/req_valid got %b/%b want 0/0", name, lsu_busy, bus.req_valid);
      end
      @(posedge clk); #1;
      load = 0; store = 0;
      vectors++;
      if (lsu_err !== 1'b1 || bus.req_valid !== 1'b0 || lsu_rdata !== last_rdata) begin
         miscompares++;
         $display("FAIL %s err/req_valid/rdata got %b/%b/%h want 1/0/%h", name, lsu_err, bus.req_valid, lsu_rdata, last_rdata);
      end
      @(posedge clk); #1;
      vectors++;
      if (lsu_err !== 1'b0) begin
         miscompares++;
         $display("FAIL %s err pulse width got still %b want 0", name, lsu_err);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.req_valid !== 1'b0 || lsu_busy !== 1'b0 || lsu_err !== 1'b0 || lsu_rdata !== 32'h0 ||
          bus.req_we !== 1'b0 || bus.req_wmask !== 4'h0 || bus.req_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset valid/busy/err/rdata/we/wmask/addr got %b/%b/%b/%h/%b/%h/%h want all 0",
                  bus.req_valid, lsu_busy, lsu_err, lsu_rdata, bus.req_we, bus.req_wmask, bus.req_addr);
      end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_load_word;
      run_access(0, 8'h0F, 2'b00, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, "lw");
      run_access(0, 8'h0F, 2'b00, 32'h8000_0010, 32'h0, 32'h0123_4567, 1, "lw_wait");
   endtask

   task automatic test_load_ext;
      run_access(0, 8'h01, 2'b01, 32'h1000_0003, 32'h0, 32'h8011_2233, 0, "lb_off3");
      run_access(0, 8'h01, 2'b00, 32'h1000_0003, 32'h0, 32'h8011_2233, 0, "lbu_off3");
      run_access(0, 8'h01, 2'b01, 32'h1000_0001, 32'h0, 32'h8011_2233, 0, "lb_off1");
      run_access(0, 8'h03, 2'b10, 32'h1000_0002, 32'h0, 32'h8011_2233, 0, "lh_off2");
      run_access(0, 8'h03, 2'b00, 32'h1000_0002, 32'h0, 32'h8011_2233, 0, "lhu_off2");
      run_access(0, 8'h03, 2'b10, 32'h1000_0000, 32'h0, 32'h1234_F00D, 0, "lh_off0");
   endtask

   task automatic test_store;
      run_access(1, 8'h03, 2'b00, 32'h2000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, "sh");
      run_access(1, 8'h01, 2'b00, 32'h2000_0001, 32'h1234_5677, 32'hFFFF_FFFF, 0, "sb");
      run_access(1, 8'h0F, 2'b00, 32'h2000_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, "sw");
   endtask

   task automatic test_illegal;
      try_illegal(1, 0, 8'h0F, 32'h3000_0002, "lw_misaligned");
      try_illegal(1, 0, 8'h03, 32'h3000_0001, "lh_misaligned");
      try_illegal(0, 1, 8'h0F, 32'h3000_0003, "sw_misaligned");
      try_illegal(1, 1, 8'h0F, 32'h3000_0000, "load_and_store");
   endtask

   task automatic test_timeout;
      run_access(0, 8'h0F, 2'b00, 32'h4000_0000, 32'h0, 32'h7777_7777, 1000, "timeout");
   endtask

   task automatic test_back_to_back;
      run_access(0, 8'h0F, 2'b00, 32'h6000_0000, 32'h0, 32'hA5A5_5A5A, 0, "b2b_first");
      run_access(0, 8'h01, 2'b00, 32'h6000_0002, 32'h0, 32'h00C3_0000, 0, "b2b_second");
      run_access(1, 8'h0F, 2'b00, 32'h6000_0004, 32'h1111_2222, 32'h0, 0, "b2b_third");
   endtask

   task automatic test_async_reset;
      @(posedge clk); #1;
      load = 1; op_PMEM = 8'h0F; op_load_sext = 0; addr = 32'h5000_0000;
      @(negedge clk);
      @(negedge clk);
      bus.req_ready = 1;
      @(negedge clk);
      bus.req_ready = 0;
      vectors++;
      if (lsu_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL areset busy_in_resp got %b want 1", lsu_busy);
      end
      load = 0;
      rst_n = 0;
      #1;
      last_rdata = 32'h0;
      vectors++;
      if (bus.req_valid !== 1'b0 || lsu_rdata !== 32'h0 || lsu_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL areset immediate valid/rdata/busy got %b/%h/%b want 0/0/0", bus.req_valid, lsu_rdata, lsu_busy);
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      bus.rsp_valid = 1; bus.rsp_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.rsp_valid = 0;
      @(negedge clk);
      vectors++;
      if (lsu_rdata !== 32'h0 || lsu_busy !== 1'b0 || bus.req_valid !== 1'b0 || lsu_err !== 1'b0) begin
         miscompares++;
         $display("FAIL late_rsp rdata/busy/valid/err got %h/%b/%b/%b want 0/0/0/0", lsu_rdata, lsu_busy, bus.req_valid, lsu_err);
      end
      run_access(0, 8'h01, 2'b01, 32'h5000_0000, 32'h0, 32'h0000_00FE, 0, "after_reset");
   endtask

   initial begin
      bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0;
      test_reset();
      test_load_word();
      test_load_ext();
      test_store();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
